// File: rtl/seq_cmp.sv
// Multi-cycle magnitude comparator: walks the operands MSB-first, CHUNK bits per
// cycle, and stops at the first chunk that differs. Signed mode uses offset binary.
module seq_cmp #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0]    LAST     = KW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {IDLE, CMP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
  logic [CHUNK-1:0] chunkA, chunkB;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  // Operands shift left after each equal chunk, so the active chunk is always at the top.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    chunkA  = a_q[WIDTH-1 -: CHUNK];
    chunkB  = b_q[WIDTH-1 -: CHUNK];
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = sign ? (a ^ MSB_MASK) : a;
          b_d     = sign ? (b ^ MSB_MASK) : b;
          k_d     = '0;
          state_d = CMP;
        end
      end
      CMP: begin
        if (chunkA != chunkB) begin
          gt_d    = (chunkA > chunkB);
          lt_d    = (chunkA < chunkB);
          eq_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (k_q == LAST) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          k_d = k_q + 1'b1;
          a_d = a_q << CHUNK;
          b_d = b_q << CHUNK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == CMP);
  assign done = done_q;
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_seq_cmp.sv
// Directed and random checks of seq_cmp at 16/4, 32/8 and 8/8 operand/chunk sizes.
module tb_seq_cmp;

  logic        clk;
  logic        rst;
  logic [2:0]  startV;
  logic [31:0] aBus, bBus;
  logic        signIn;
  logic [2:0]  busyV, doneV, gtV, eqV, ltV;
  int          checks, errors;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [2:0]  res;
    int          lat;
  } vec_t;

  seq_cmp #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .start(startV[0]), .a(aBus[15:0]), .b(bBus[15:0]), .sign(signIn),
    .busy(busyV[0]), .done(doneV[0]), .gt(gtV[0]), .eq(eqV[0]), .lt(ltV[0]));

  seq_cmp #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .start(startV[1]), .a(aBus), .b(bBus), .sign(signIn),
    .busy(busyV[1]), .done(doneV[1]), .gt(gtV[1]), .eq(eqV[1]), .lt(ltV[1]));

  seq_cmp #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(startV[2]), .a(aBus[7:0]), .b(bBus[7:0]), .sign(signIn),
    .busy(busyV[2]), .done(doneV[2]), .gt(gtV[2]), .eq(eqV[2]), .lt(ltV[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Starts one operation on the selected DUT and reports {gt,eq,lt} and cycles to done (-1 on timeout).
  task automatic applyStimulus(input int sel, input logic [31:0] av, input logic [31:0] bv,
                               input logic sv, output logic [2:0] res, output int lat);
    aBus        = av;
    bBus        = bv;
    signIn      = sv;
    startV[sel] = 1'b1;
    @(posedge clk);
    #1;
    startV[sel] = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (doneV[sel]) begin
        lat = c;
        break;
      end
    end
    res = {gtV[sel], eqV[sel], ltV[sel]};
  endtask

  function automatic logic [2:0] modelRes(int w, logic [31:0] av, logic [31:0] bv, logic s);
    longint sa, sb;
    sa = longint'(av);
    sb = longint'(bv);
    if (s && av[w-1]) sa = sa - (longint'(1) << w);
    if (s && bv[w-1]) sb = sb - (longint'(1) << w);
    if (sa > sb) return 3'b100;
    if (sa < sb) return 3'b001;
    return 3'b010;
  endfunction

  function automatic int modelLat(int w, int ch, logic [31:0] av, logic [31:0] bv);
    logic [31:0] x;
    int n;
    n = w / ch;
    for (int k = 0; k < n; k++) begin
      x = (av ^ bv) >> (w - (k + 1) * ch);
      if ((x & ((32'd1 << ch) - 32'd1)) != 0) return k + 1;
    end
    return n;
  endfunction

  task automatic sweep(input int sel, input int w, input int ch);
    logic [31:0] mask, av, bv;
    logic        sv;
    logic [2:0]  res;
    int          lat, j;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    for (int i = 0; i < 200; i++) begin
      av = $urandom & mask;
      j  = $urandom_range(0, w / ch);
      bv = (j == w / ch) ? av : ((av ^ ($urandom >> (j * ch))) & mask);
      sv = 1'($urandom_range(0, 1));
      applyStimulus(sel, av, bv, sv, res, lat);
      checkOutput($sformatf("sweep%0d res %h/%h s%0d", w, av, bv, sv), int'(res), int'(modelRes(w, av, bv, sv)));
      checkOutput($sformatf("sweep%0d lat %h/%h", w, av, bv), lat, modelLat(w, ch, av, bv));
    end
  endtask

  initial begin
    vec_t        vecs[11];
    logic [2:0]  res;
    int          lat, doneCnt, firstDone, secondDone;
    logic [2:0]  resFirst, resSecond;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    startV = '0;
    aBus   = '0;
    bBus   = '0;
    signIn = 1'b0;

    vecs[0]  = '{16'd1,    16'd2,    1'b1, 3'b001, 4};
    vecs[1]  = '{16'd257,  16'd256,  1'b1, 3'b100, 4};
    vecs[2]  = '{16'd256,  16'd256,  1'b1, 3'b010, 4};
    vecs[3]  = '{16'd2,    16'hFFFF, 1'b1, 3'b100, 1};
    vecs[4]  = '{16'hFF00, 16'hFEFF, 1'b1, 3'b100, 2};
    vecs[5]  = '{16'hFEFF, 16'hFF00, 1'b1, 3'b001, 2};
    vecs[6]  = '{16'h0002, 16'hFFFF, 1'b0, 3'b001, 1};
    vecs[7]  = '{16'h8000, 16'h7FFF, 1'b0, 3'b100, 1};
    vecs[8]  = '{16'h1234, 16'h1243, 1'b0, 3'b001, 3};
    vecs[9]  = '{16'h8000, 16'h8000, 1'b1, 3'b010, 4};
    vecs[10] = '{16'h7FFF, 16'h8000, 1'b1, 3'b100, 1};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", int'(busyV), 0);
    checkOutput("reset done", int'(doneV), 0);
    checkOutput("reset gt",   int'(gtV), 0);
    checkOutput("reset eq",   int'(eqV), 0);
    checkOutput("reset lt",   int'(ltV), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(0, {16'h0, vecs[i].a}, {16'h0, vecs[i].b}, vecs[i].s, res, lat);
      checkOutput($sformatf("vec%0d result", i), int'(res), int'(vecs[i].res));
      checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].lat);
    end

    // Start held through the busy period must be ignored; raised in the done cycle it is accepted.
    aBus = 32'd1; bBus = 32'd2; signIn = 1'b0; startV[0] = 1'b1;
    @(posedge clk);
    #1;
    aBus = 32'd5; bBus = 32'd5;
    doneCnt = 0; firstDone = -1; secondDone = -1; resFirst = '0; resSecond = '0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) startV[0] = 1'b0;
      if (doneV[0]) begin
        doneCnt++;
        if (firstDone < 0) begin
          firstDone = c;
          resFirst  = {gtV[0], eqV[0], ltV[0]};
          aBus = 32'd3; bBus = 32'd3;
        end else begin
          secondDone = c;
          resSecond  = {gtV[0], eqV[0], ltV[0]};
        end
      end
    end
    startV[0] = 1'b0;
    checkOutput("hs done count", doneCnt, 2);
    checkOutput("hs first done", firstDone, 4);
    checkOutput("hs first result", int'(resFirst), 3'b001);
    checkOutput("hs second done", secondDone, 9);
    checkOutput("hs second result", int'(resSecond), 3'b010);

    // Asynchronous reset mid-compare: outputs clear at once and no done follows.
    aBus = 32'd1; bBus = 32'd2; signIn = 1'b0; startV[0] = 1'b1;
    @(posedge clk);
    #1;
    startV[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort busy", int'(busyV[0]), 0);
    checkOutput("abort done", int'(doneV[0]), 0);
    checkOutput("abort results", int'({gtV[0], eqV[0], ltV[0]}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    doneCnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (doneV[0]) doneCnt++;
    end
    checkOutput("abort no done", doneCnt, 0);
    applyStimulus(0, 32'd7, 32'd7, 1'b0, res, lat);
    checkOutput("post reset result", int'(res), 3'b010);
    checkOutput("post reset latency", lat, 4);

    sweep(1, 32, 8);
    sweep(2, 8, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
